adc_cmd_controller: RTL and testbench
=====================================

// Module: adc_cmd_controller
// PURPOSE
//  Command sequencer between the rx/tx byte FIFOs and the peripherals. Decodes host
//  command bytes, runs single or burst ADC conversions on a selectable channel and
//  streams framed results into the tx FIFO. Drives the shutter servo PWM. Detects
//  ADC stalls with a timeout. Invalid commands get an error byte back.
// PARAMETERS
//  NUM_CH       8        ADC channels; channel field is 4 bits, so NUM_CH <= 16
//  ADC_W        32       ADC result width; must be a multiple of 8
//  DATA_BYTES   ADC_W/8  payload bytes per sample, sent LSB first
//  TIMEOUT      4096     max cycles to wait for adc_busy rise, and again for its fall
//  PWM_CNT_W    18       PWM period counter width; duty compares its top 8 bits
//  OPEN_DUTY    8'h50    shutter open duty (~800 us)
//  CLOSED_DUTY  8'h96    shutter closed duty (~1500 us)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      synchronous active-low reset
//  rx_rdata     in   8      rx FIFO head byte, valid while rx_rempty=0 (first-word fall-through)
//  rx_rempty    in   1      rx FIFO empty
//  rx_rinc      out  1      rx FIFO pop
//  tx_wdata     out  8      tx FIFO write data
//  tx_winc      out  1      tx FIFO push
//  tx_wfull     in   1      tx FIFO full
//  adc_sample   out  1      conversion request, held until adc_busy=1
//  adc_ch       out  4      selected channel, stable from ADC_START to end of burst
//  adc_busy     in   1      ADC interface busy
//  adc_data     in   ADC_W  conversion result, valid once adc_busy falls
//  pwm_shutter  out  1      servo PWM
//  busy         out  1      1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; all outputs 0; adc_ch=0; shutter=closed;
//   PWM counter=0; burst counter=0; timeout counter=0.
//  Commands (opcode=[7:4], arg=[3:0]):
//   0x1c  GET_ADC: one sample on channel c.
//   0x2_  arg 0 = SHUTTER_OPEN, arg 1 = SHUTTER_CLOSE; sends no reply.
//   0x3c  BURST: next byte N, then N+1 samples on channel c (N=0xFF gives 256).
//   Any other byte, or c >= NUM_CH -> ERR_CMD byte 0xEE.
//  FSM (one transition per clk):
//   IDLE      : if !rx_rempty then rx_rinc=1 (same cycle), latch rx_rdata -> DECODE.
//   DECODE    : shutter cmd -> update shutter, IDLE; GET_ADC -> latch adc_ch, burst=0,
//               ADC_START; BURST -> ARG_WAIT; invalid -> TX_ERR(0xEE).
//   ARG_WAIT  : if !rx_rempty then pop, burst=rx_rdata -> ADC_START. No timeout here.
//   ADC_START : adc_sample=1; adc_busy=1 -> ADC_WAIT; TIMEOUT cycles elapse -> TX_ERR(0xEF).
//   ADC_WAIT  : adc_busy=0 -> latch adc_data, byte_idx=0 -> TX_HDR;
//               TIMEOUT cycles elapse -> TX_ERR(0xEF).
//   TX_HDR    : byte {4'hA, adc_ch} -> TX_DATA.
//   TX_DATA   : byte = latched[8*byte_idx +: 8]; after byte DATA_BYTES-1:
//               burst==0 -> IDLE, else burst-- -> ADC_START.
//   TX_ERR    : error byte -> IDLE.
//  Every TX_* state sets tx_winc = !tx_wfull. The state/index advances only on an
//   accepted write. tx_winc is never 1 while tx_wfull=1; no byte is dropped or repeated.
//  Timeout counter clears on every state entry. Error fires on count == TIMEOUT-1.
//  rx_rinc is never 1 while rx_rempty=1; exactly one pop per command/argument byte.
//  Latency: GET_ADC pop -> ADC_START asserted 2 clks later; first tx_winc 1 clk after
//   adc_busy falls (tx not full).
//  A shutter command received during a burst waits in the rx FIFO until IDLE.
//  Reset mid-burst: abort immediately; partial frames are not completed.
//  PWM: counter free-runs and wraps. pwm_shutter <= (cnt[PWM_CNT_W-1 -: 8] <= duty),
//   registered. duty = OPEN_DUTY/CLOSED_DUTY from shutter state, updated at the wrap only.
// STRUCTURE
//  controller.vh: opcodes, header nibble 4'hA, ERR_CMD 8'hEE, ERR_TIMEOUT 8'hEF,
//   state encodings.
//  Sub-module servo_pwm (clk, rst_n, duty[7:0], pwm): counter, wrap-aligned duty
//   latch, comparator.
//  The FSM, burst/byte/timeout counters and data latch stay in this module.
// TESTING
//  1 rx 0x13, ADC model returns 32'hDEADBEEF -> tx bytes A3 EF BE AD DE; adc_ch=3; busy back to 0.
//  2 rx 0x32,0x02 -> 3 frames A2+4 bytes (15 bytes total); adc_sample pulses 3 times.
//  3 tx_wfull held high 50 clks mid-frame -> tx_winc stays 0; byte order intact after release.
//  4 rx 0x1F (NUM_CH=8) -> single 0xEE; rx 0x55 -> 0xEE; no adc_sample.
//  5 adc_busy never rises -> 0xEF after TIMEOUT clks; next 0x10 works normally.
//  6 rx 0x20 then 0x21 -> duty change only at counter wrap; rst_n low mid-burst -> outputs 0 next clk.

Source files
------------

// File: rtl/adc_cmd_controller_pkg.sv
// Shared encodings for the ADC command controller: opcodes, reply bytes and FSM states.
package adc_cmd_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_ARG_WAIT,
    ST_ADC_START,
    ST_ADC_WAIT,
    ST_TX_HDR,
    ST_TX_DATA,
    ST_TX_ERR
  } state_t;

  localparam logic [3:0] OP_GET_ADC        = 4'h1;
  localparam logic [3:0] OP_SHUTTER        = 4'h2;
  localparam logic [3:0] OP_BURST          = 4'h3;
  localparam logic [3:0] ARG_SHUTTER_OPEN  = 4'h0;
  localparam logic [3:0] ARG_SHUTTER_CLOSE = 4'h1;
  localparam logic [3:0] HDR_NIBBLE        = 4'hA;
  localparam logic [7:0] ERR_CMD           = 8'hEE;
  localparam logic [7:0] ERR_TIMEOUT       = 8'hEF;

  function automatic logic ch_valid(input logic [3:0] ch, input int num_ch);
    return int'({28'd0, ch}) < num_ch;
  endfunction

endpackage

// File: rtl/adc_cmd_controller_servo_pwm.sv
// Servo PWM generator: free-running counter, duty latched only at the counter wrap so
// a pulse in progress is never cut short or stretched.
module adc_cmd_controller_servo_pwm #(
  parameter int         CNT_W      = 18,
  parameter logic [7:0] RESET_DUTY = 8'h96
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] duty,
  output logic       pwm
);

  logic [CNT_W-1:0] cnt_reg;
  logic [7:0]       duty_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      duty_reg <= RESET_DUTY;
      pwm      <= 1'b0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      if (&cnt_reg) begin
        duty_reg <= duty;
      end
      pwm <= (cnt_reg[CNT_W-1 -: 8] <= duty_reg);
    end
  end

endmodule

// File: rtl/adc_cmd_controller.sv
// Host command sequencer: pops command bytes from the rx FIFO, runs single or burst ADC
// conversions, frames the results into the tx FIFO and drives the shutter servo.
module adc_cmd_controller
  import adc_cmd_controller_pkg::*;
#(
  parameter int         NUM_CH      = 8,
  parameter int         ADC_W       = 32,
  parameter int         TIMEOUT     = 4096,
  parameter int         PWM_CNT_W   = 18,
  parameter logic [7:0] OPEN_DUTY   = 8'h50,
  parameter logic [7:0] CLOSED_DUTY = 8'h96
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_rdata,
  input  logic             rx_rempty,
  output logic             rx_rinc,
  output logic [7:0]       tx_wdata,
  output logic             tx_winc,
  input  logic             tx_wfull,
  output logic             adc_sample,
  output logic [3:0]       adc_ch,
  input  logic             adc_busy,
  input  logic [ADC_W-1:0] adc_data,
  output logic             pwm_shutter,
  output logic             busy
);

  localparam int DATA_BYTES = ADC_W / 8;
  localparam int IDX_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TMO_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_t           state_reg;
  logic [7:0]       cmd_reg;
  logic [3:0]       adc_ch_reg;
  logic [7:0]       burst_reg;
  logic [IDX_W-1:0] byte_idx_reg;
  logic [TMO_W-1:0] tmo_reg;
  logic [ADC_W-1:0] data_reg;
  logic [7:0]       err_reg;
  logic             shutter_open_reg;
  logic [7:0]       data_bytes [DATA_BYTES];

  wire [3:0] cmd_op  = cmd_reg[7:4];
  wire [3:0] cmd_arg = cmd_reg[3:0];
  wire       arg_ok  = ch_valid(cmd_arg, NUM_CH);
  wire       tx_state = (state_reg == ST_TX_HDR) || (state_reg == ST_TX_DATA) ||
                        (state_reg == ST_TX_ERR);

  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_data_bytes
    assign data_bytes[gi] = data_reg[8*gi +: 8];
  end

  // Handshakes are gated by the live FIFO flags so a pop or push can never hit an
  // empty/full FIFO, and by rst_n so nothing moves while the FSM is held in reset.
  assign rx_rinc    = rst_n && !rx_rempty &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_ARG_WAIT));
  assign tx_winc    = rst_n && !tx_wfull && tx_state;
  assign adc_sample = (state_reg == ST_ADC_START);
  assign adc_ch     = adc_ch_reg;
  assign busy       = (state_reg != ST_IDLE);

  always_comb begin
    tx_wdata = 8'h00;
    case (state_reg)
      ST_TX_HDR:  tx_wdata = {HDR_NIBBLE, adc_ch_reg};
      ST_TX_DATA: tx_wdata = data_bytes[byte_idx_reg];
      ST_TX_ERR:  tx_wdata = err_reg;
      default:    tx_wdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      cmd_reg          <= '0;
      adc_ch_reg       <= '0;
      burst_reg        <= '0;
      byte_idx_reg     <= '0;
      tmo_reg          <= '0;
      data_reg         <= '0;
      err_reg          <= '0;
      shutter_open_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!rx_rempty) begin
            cmd_reg   <= rx_rdata;
            state_reg <= ST_DECODE;
          end
        end

        ST_DECODE: begin
          tmo_reg <= '0;
          if (cmd_op == OP_GET_ADC && arg_ok) begin
            adc_ch_reg <= cmd_arg;
            burst_reg  <= '0;
            state_reg  <= ST_ADC_START;
          end else if (cmd_op == OP_BURST && arg_ok) begin
            adc_ch_reg <= cmd_arg;
            state_reg  <= ST_ARG_WAIT;
          end else if (cmd_op == OP_SHUTTER && cmd_arg == ARG_SHUTTER_OPEN) begin
            shutter_open_reg <= 1'b1;
            state_reg        <= ST_IDLE;
          end else if (cmd_op == OP_SHUTTER && cmd_arg == ARG_SHUTTER_CLOSE) begin
            shutter_open_reg <= 1'b0;
            state_reg        <= ST_IDLE;
          end else begin
            err_reg   <= ERR_CMD;
            state_reg <= ST_TX_ERR;
          end
        end

        ST_ARG_WAIT: begin
          if (!rx_rempty) begin
            burst_reg <= rx_rdata;
            tmo_reg   <= '0;
            state_reg <= ST_ADC_START;
          end
        end

        ST_ADC_START: begin
          if (adc_busy) begin
            tmo_reg   <= '0;
            state_reg <= ST_ADC_WAIT;
          end else if (tmo_reg == TMO_LAST) begin
            err_reg   <= ERR_TIMEOUT;
            state_reg <= ST_TX_ERR;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end

        ST_ADC_WAIT: begin
          if (!adc_busy) begin
            data_reg     <= adc_data;
            byte_idx_reg <= '0;
            state_reg    <= ST_TX_HDR;
          end else if (tmo_reg == TMO_LAST) begin
            err_reg   <= ERR_TIMEOUT;
            state_reg <= ST_TX_ERR;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end

        ST_TX_HDR: begin
          if (!tx_wfull) begin
            state_reg <= ST_TX_DATA;
          end
        end

        // burst_reg counts the samples still owed after the current one
        ST_TX_DATA: begin
          if (!tx_wfull) begin
            if (byte_idx_reg == LAST_IDX) begin
              if (burst_reg == 8'd0) begin
                state_reg <= ST_IDLE;
              end else begin
                burst_reg <= burst_reg - 1'b1;
                tmo_reg   <= '0;
                state_reg <= ST_ADC_START;
              end
            end else begin
              byte_idx_reg <= byte_idx_reg + 1'b1;
            end
          end
        end

        ST_TX_ERR: begin
          if (!tx_wfull) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  adc_cmd_controller_servo_pwm #(
    .CNT_W      (PWM_CNT_W),
    .RESET_DUTY (CLOSED_DUTY)
  ) u_servo_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .duty  (shutter_open_reg ? OPEN_DUTY : CLOSED_DUTY),
    .pwm   (pwm_shutter)
  );

endmodule

// File: tb/tb_adc_cmd_controller.sv
// Bench for adc_cmd_controller: FIFO and ADC models around the DUT, tx bytes checked
// against a queue of expected bytes filled when each command is issued.
module tb_adc_cmd_controller;

  localparam int NUM_CH     = 8;
  localparam int ADC_W      = 32;
  localparam int TIMEOUT    = 64;
  localparam int PWM_CNT_W  = 10;
  localparam int HIGH_CLOSED = (8'h96 + 1) << (PWM_CNT_W - 8);
  localparam int HIGH_OPEN   = (8'h50 + 1) << (PWM_CNT_W - 8);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_rdata = 8'h00;
  logic             rx_rempty = 1'b1;
  logic             rx_rinc;
  logic [7:0]       tx_wdata;
  logic             tx_winc;
  logic             tx_wfull = 1'b0;
  logic             adc_sample;
  logic [3:0]       adc_ch;
  logic             adc_busy = 1'b0;
  logic [ADC_W-1:0] adc_data = '0;
  logic             pwm_shutter;
  logic             busy;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] adc_vals[$];
  int errors = 0;
  int checks = 0;
  int sample_count = 0;
  bit sb_enable = 1'b1;
  bit adc_respond = 1'b1;

  logic pop_s, empty_s, wr_s, full_s;
  logic [7:0] wdata_s;

  adc_cmd_controller #(
    .NUM_CH      (NUM_CH),
    .ADC_W       (ADC_W),
    .TIMEOUT     (TIMEOUT),
    .PWM_CNT_W   (PWM_CNT_W),
    .OPEN_DUTY   (8'h50),
    .CLOSED_DUTY (8'h96)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdata    (rx_rdata),
    .rx_rempty   (rx_rempty),
    .rx_rinc     (rx_rinc),
    .tx_wdata    (tx_wdata),
    .tx_winc     (tx_winc),
    .tx_wfull    (tx_wfull),
    .adc_sample  (adc_sample),
    .adc_ch      (adc_ch),
    .adc_busy    (adc_busy),
    .adc_data    (adc_data),
    .pwm_shutter (pwm_shutter),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // FIFO models: handshakes sampled mid-cycle, acted on just after the edge.
  always @(negedge clk) begin
    pop_s   = rx_rinc;
    empty_s = rx_rempty;
    wr_s    = tx_winc;
    full_s  = tx_wfull;
    wdata_s = tx_wdata;
  end

  always @(posedge clk) begin
    logic [7:0] exp_b;
    #1;
    if (pop_s) begin
      if (empty_s) begin
        checks++;
        errors++;
        $display("FAIL rx_pop_empty: rx_rinc=1 with rx_rempty=1");
      end else begin
        exp_b = rx_q.pop_front();
      end
    end
    rx_rempty = (rx_q.size() == 0);
    rx_rdata  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    if (wr_s) begin
      if (full_s) begin
        checks++;
        errors++;
        $display("FAIL tx_push_full: tx_winc=1 with tx_wfull=1");
      end else if (sb_enable) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected: got byte %h, none expected", wdata_s);
        end else begin
          exp_b = exp_q.pop_front();
          $display("tx byte %h (expected %h)", wdata_s, exp_b);
          if (wdata_s !== exp_b) begin
            errors++;
            $display("FAIL tx_byte: got %h, want %h", wdata_s, exp_b);
          end
        end
      end
    end
    pop_s = 1'b0;
    wr_s  = 1'b0;
  end

  // ADC model: busy rises 2 clks after the request, result valid 3 clks later.
  initial begin
    forever begin
      @(negedge clk);
      if (adc_sample && adc_respond) begin
        sample_count++;
        repeat (2) @(posedge clk);
        #2 adc_busy = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        adc_data = (adc_vals.size() != 0) ? adc_vals.pop_front() : '0;
        adc_busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_frame(input logic [3:0] ch, input logic [31:0] val);
    adc_vals.push_back(val);
    exp_q.push_back({4'hA, ch});
    for (int i = 0; i < 4; i++) exp_q.push_back(val[8*i +: 8]);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rx_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes outstanding, busy=%b, want 0 and 0", name, exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) step();
    @(negedge clk);
    checks++;
    if ({tx_winc, rx_rinc, adc_sample, busy, pwm_shutter} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, want 00000", {tx_winc, rx_rinc, adc_sample, busy, pwm_shutter});
    end
    checks++;
    if (adc_ch !== 4'h0 || tx_wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: adc_ch=%h tx_wdata=%h, want 0 00", adc_ch, tx_wdata);
    end
    step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b, want 0", busy);
    end
    $display("reset done");
  endtask

  task automatic test_get_adc();
    int n;
    expect_frame(4'h3, 32'hDEADBEEF);
    rx_q.push_back(8'h13);
    n = 0;
    do begin @(negedge clk); n++; end while (!rx_rinc && n < 20);
    @(negedge clk);
    checks++;
    if (adc_sample !== 1'b0) begin
      errors++;
      $display("FAIL get_adc_early_sample: got %b one clk after pop, want 0", adc_sample);
    end
    @(negedge clk);
    checks++;
    if (adc_sample !== 1'b1) begin
      errors++;
      $display("FAIL get_adc_start_latency: got %b two clks after pop, want 1", adc_sample);
    end
    n = 0;
    while (!adc_busy && n < 50) begin @(negedge clk); n++; end
    while (adc_busy && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (tx_winc !== 1'b0) begin
      errors++;
      $display("FAIL get_adc_tx_early: tx_winc=%b as busy falls, want 0", tx_winc);
    end
    @(negedge clk);
    checks++;
    if (tx_winc !== 1'b1 || tx_wdata !== 8'hA3) begin
      errors++;
      $display("FAIL get_adc_first_tx: winc=%b data=%h, want 1 a3", tx_winc, tx_wdata);
    end
    wait_drain("get_adc", 200);
    checks++;
    if (adc_ch !== 4'h3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL get_adc_final: adc_ch=%h busy=%b, want 3 0", adc_ch, busy);
    end
    $display("get_adc done");
  endtask

  task automatic test_burst();
    int sc0 = sample_count;
    expect_frame(4'h2, 32'h01234567);
    expect_frame(4'h2, 32'h89ABCDEF);
    expect_frame(4'h2, 32'h55AA0FF0);
    rx_q.push_back(8'h32);
    rx_q.push_back(8'h02);
    wait_drain("burst", 400);
    checks++;
    if (sample_count - sc0 !== 3) begin
      errors++;
      $display("FAIL burst_samples: got %0d conversions, want 3", sample_count - sc0);
    end
    checks++;
    if (adc_ch !== 4'h2) begin
      errors++;
      $display("FAIL burst_ch: got %h, want 2", adc_ch);
    end
    $display("burst done");
  endtask

  task automatic test_backpressure();
    int n = 0;
    int bad = 0;
    expect_frame(4'h5, 32'h11223344);
    rx_q.push_back(8'h15);
    while (exp_q.size() > 3 && n < 200) begin step(); n++; end
    tx_wfull = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_winc) bad++;
    end
    checks++;
    if (bad !== 0 || exp_q.size() !== 3) begin
      errors++;
      $display("FAIL backpressure_hold: %0d pushes while full, %0d left, want 0 and 3", bad, exp_q.size());
    end
    step();
    tx_wfull = 1'b0;
    wait_drain("backpressure", 200);
    $display("backpressure done");
  endtask

  task automatic test_invalid();
    int sc0 = sample_count;
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'hEE);
    rx_q.push_back(8'h1F);
    rx_q.push_back(8'h55);
    wait_drain("invalid", 200);
    checks++;
    if (sample_count !== sc0) begin
      errors++;
      $display("FAIL invalid_no_sample: got %0d conversions, want 0", sample_count - sc0);
    end
    $display("invalid done");
  endtask

  task automatic test_timeout();
    int n = 0;
    int hi = 0;
    adc_respond = 1'b0;
    exp_q.push_back(8'hEF);
    rx_q.push_back(8'h14);
    while (!adc_sample && n < 50) begin @(negedge clk); n++; end
    while (adc_sample && hi < 4 * TIMEOUT) begin @(negedge clk); hi++; end
    checks++;
    if (hi !== TIMEOUT) begin
      errors++;
      $display("FAIL timeout_len: request held %0d clks, want %0d", hi, TIMEOUT);
    end
    checks++;
    if (tx_winc !== 1'b1 || tx_wdata !== 8'hEF) begin
      errors++;
      $display("FAIL timeout_err_byte: winc=%b data=%h, want 1 ef", tx_winc, tx_wdata);
    end
    wait_drain("timeout", 50);
    adc_respond = 1'b1;
    expect_frame(4'h0, 32'hCAFEF00D);
    rx_q.push_back(8'h10);
    wait_drain("after_timeout", 200);
    $display("timeout done");
  endtask

  task automatic wait_rise(output bit ok);
    logic prev;
    ok = 1'b0;
    @(negedge clk);
    prev = pwm_shutter;
    for (int n = 0; n < 2 * (1 << PWM_CNT_W) && !ok; n++) begin
      @(negedge clk);
      if (!prev && pwm_shutter) ok = 1'b1;
      prev = pwm_shutter;
    end
  endtask

  task automatic pulse_width(output int width);
    width = 1;
    for (int n = 0; n < 2 * (1 << PWM_CNT_W); n++) begin
      @(negedge clk);
      if (!pwm_shutter) break;
      width++;
    end
  endtask

  task automatic test_shutter();
    bit ok;
    int w;
    wait_rise(ok);
    rx_q.push_back(8'h20);
    pulse_width(w);
    checks++;
    if (!ok || w !== HIGH_CLOSED) begin
      errors++;
      $display("FAIL shutter_open_same_period: width %0d, want %0d", w, HIGH_CLOSED);
    end
    wait_rise(ok);
    rx_q.push_back(8'h21);
    pulse_width(w);
    checks++;
    if (!ok || w !== HIGH_OPEN) begin
      errors++;
      $display("FAIL shutter_open_width: width %0d, want %0d", w, HIGH_OPEN);
    end
    wait_rise(ok);
    pulse_width(w);
    checks++;
    if (!ok || w !== HIGH_CLOSED) begin
      errors++;
      $display("FAIL shutter_closed_width: width %0d, want %0d", w, HIGH_CLOSED);
    end
    wait_drain("shutter", 20);
    $display("shutter done");
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    int sc0 = sample_count;
    sb_enable = 1'b0;
    rx_q.push_back(8'h33);
    rx_q.push_back(8'hFF);
    while (sample_count < sc0 + 2 && n < 300) begin step(); n++; end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_winc, rx_rinc, adc_sample, busy, pwm_shutter} !== 5'b0 || adc_ch !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_burst: ctrl=%b adc_ch=%h, want 00000 0",
               {tx_winc, rx_rinc, adc_sample, busy, pwm_shutter}, adc_ch);
    end
    step();
    rst_n = 1'b1;
    n = 0;
    while (adc_busy && n < 50) begin step(); n++; end
    repeat (10) step();
    exp_q.delete();
    adc_vals.delete();
    sb_enable = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b after reset, want 0", busy);
    end
    expect_frame(4'h7, 32'h0BADF00D);
    rx_q.push_back(8'h17);
    wait_drain("recover", 200);
    checks++;
    if (adc_ch !== 4'h7) begin
      errors++;
      $display("FAIL recover_ch: got %h, want 7", adc_ch);
    end
    $display("reset_mid_burst done");
  endtask

  initial begin
    test_reset();
    test_get_adc();
    test_burst();
    test_backpressure();
    test_invalid();
    test_timeout();
    test_shutter();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
